// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes sck/cs_n/mosi into clk, shifts 8-bit bytes MSB first.
// Optional frame-error pulse on a truncated frame is enabled with `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES + 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic [2:0]             settle_cnt;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_sr;
    logic [7:0]             tx_sr;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic settled;
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronizers restart at idle level 1 after reset; until the chain and the
    // delay flop hold real pin values, a cs_n "fall" is an artefact and is ignored.
    assign settled  = (settle_cnt == SETTLE_CYCLES);
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = settled & ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    assign miso = (state == ACTIVE) ? tx_sr[7] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync   <= '1;
            cs_sync    <= '1;
            mosi_sync  <= '1;
            sck_d      <= 1'b1;
            cs_d       <= 1'b1;
            settle_cnt <= 3'd0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d      <= sck_s;
            cs_d       <= cs_s;
            if (!settled) begin
                settle_cnt <= settle_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        bit_cnt <= 3'd0;
                        tx_sr   <= tx_data;
                        tx_load <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // cs_n deassertion takes priority over a coincident sck edge.
                    if (cs_rise) begin
                        state <= IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err <= (bit_cnt != 3'd0);
`endif
                    end else if (sck_rise) begin
                        rx_sr   <= {rx_sr[5:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_sr, mosi_s};
                            rx_valid <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_sr   <= tx_data;
                            tx_load <= 1'b1;
                        end else begin
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master drives frames and a
// byte-level model predicts received bytes, tx_load count and the bytes seen on miso.
module tb_spi_slave;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
`endif

    spi_slave #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int ferr_cnt = 0;
    int tx_idx = 0;
    int m_bits = 0;
    int last_lat = 0;
    logic [7:0] m_acc;
    logic [7:0] model_rx;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_src[$];
    logic [7:0] m_in[$];

    // Output monitor: counts pulses and serves the next tx byte after each tx_load.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            got_q.push_back(rx_data);
        end
        if (tx_load) begin
            txl_cnt++;
            tx_idx++;
            if (tx_idx < tx_src.size()) tx_data = tx_src[tx_idx];
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        rxv_cnt  = 0;
        txl_cnt  = 0;
        ferr_cnt = 0;
        got_q.delete();
        m_in.delete();
        m_bits = 0;
    endtask

    task automatic start_frame();
        tx_idx  = 0;
        tx_data = tx_src[0];
        cs_n    = 1'b0;
        wait_ticks(S + 2 + $urandom_range(0, 3));
    endtask

    task automatic send_bit(input logic b, input logic last_bit);
        int lo;
        int hi;
        lo = S + 2 + $urandom_range(0, 3);
        hi = S + 2 + $urandom_range(0, 3);
        mosi = b;
        wait_ticks(lo);
        m_acc = {m_acc[6:0], miso};
        m_bits++;
        if (m_bits == 8) begin
            m_in.push_back(m_acc);
            m_bits = 0;
        end
        sck = 1'b1;
        last_lat = 0;
        for (int k = 1; k <= hi; k++) begin
            tick();
            if (rx_valid && last_lat == 0) last_lat = k;
        end
        sck = 1'b0;
        if (last_bit) cs_n = 1'b1;
    endtask

    task automatic run_frame(input int nbits, input logic [23:0] w);
        clear_counts();
        start_frame();
        for (int b = 0; b < nbits; b++) send_bit(w[23-b], b == nbits - 1);
        wait_ticks(S + 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h00;
        tx_src.delete();
        tx_src.push_back(8'h00);
        wait_ticks(3);
        total++; if (miso !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b exp=1", miso); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0 || tx_load !== 1'b0) begin
            bad++; $display("FAIL reset_pulses got=%b%b exp=00", rx_valid, tx_load);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
`endif
        rst = 1'b0;
        clear_counts();
        wait_ticks(S + 4);
        total++; if (miso !== 1'b1 || txl_cnt != 0) begin
            bad++; $display("FAIL post_reset_idle got miso=%b txl=%0d exp miso=1 txl=0", miso, txl_cnt);
        end
        model_rx = 8'h00;
    endtask

    task automatic test_single_byte();
        tx_src.delete();
        tx_src.push_back(8'hFF);
        run_frame(8, 24'hAA0000);
        model_rx = 8'hAA;
        total++; if (rxv_cnt != 1) begin bad++; $display("FAIL single_rxv got=%0d exp=1", rxv_cnt); end
        total++; if (rx_data !== 8'hAA) begin bad++; $display("FAIL single_rx_data got=%h exp=aa", rx_data); end
        total++; if (txl_cnt != 1) begin bad++; $display("FAIL single_txl got=%0d exp=1", txl_cnt); end
        total++; if (m_in.size() != 1 || m_in[0] !== 8'hFF) begin
            bad++; $display("FAIL single_miso got=%0d bytes first=%h exp=1 bytes ff", m_in.size(), m_acc);
        end
        total++; if (last_lat != S + 1) begin bad++; $display("FAIL rx_valid_latency got=%0d exp=%0d", last_lat, S + 1); end
    endtask

    task automatic test_partial_frame();
        tx_src.delete();
        tx_src.push_back(8'h5A);
        run_frame(5, 24'hF00000);
        total++; if (rxv_cnt != 0) begin bad++; $display("FAIL partial_rxv got=%0d exp=0", rxv_cnt); end
        total++; if (rx_data !== model_rx) begin bad++; $display("FAIL partial_rx_data got=%h exp=%h", rx_data, model_rx); end
        total++; if (txl_cnt != 1) begin bad++; $display("FAIL partial_txl got=%0d exp=1", txl_cnt); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        total++; if (ferr_cnt != 1) begin bad++; $display("FAIL partial_frame_err got=%0d exp=1", ferr_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        tx_src.delete();
        tx_src.push_back(8'h3C);
        tx_src.push_back(8'h81);
        exp_q.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA5);
        run_frame(16, 24'h55A500);
        model_rx = 8'hA5;
        total++; if (rxv_cnt != 2) begin bad++; $display("FAIL b2b_rxv got=%0d exp=2", rxv_cnt); end
        for (int i = 0; i < 2; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL b2b_rx_byte%0d got=%h exp=%h", i, g, exp_q[i]); end
            g = (i < m_in.size()) ? m_in[i] : 8'hxx;
            total++; if (g !== tx_src[i]) begin bad++; $display("FAIL b2b_miso_byte%0d got=%h exp=%h", i, g, tx_src[i]); end
        end
        total++; if (txl_cnt != 2) begin bad++; $display("FAIL b2b_txl got=%0d exp=2", txl_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pat;
        pat = 8'hB6;
        tx_src.delete();
        tx_src.push_back(8'hC3);
        clear_counts();
        start_frame();
        for (int b = 0; b < 3; b++) send_bit(pat[7-b], 1'b0);
        rst = 1'b1;
        wait_ticks(2);
        total++; if (rx_data !== 8'h00 || miso !== 1'b1 || rx_valid !== 1'b0 || tx_load !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got rx=%h miso=%b v=%b l=%b exp rx=00 miso=1 v=0 l=0",
                            rx_data, miso, rx_valid, tx_load);
        end
        rst = 1'b0;
        clear_counts();
        for (int b = 3; b < 8; b++) send_bit(pat[7-b], b == 7);
        wait_ticks(S + 6);
        total++; if (rxv_cnt != 0 || txl_cnt != 0) begin
            bad++; $display("FAIL midrst_ignored got rxv=%0d txl=%0d exp 0 0", rxv_cnt, txl_cnt);
        end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_hold got=%h exp=00", rx_data); end
        tx_src.delete();
        tx_src.push_back(8'h7E);
        run_frame(8, 24'h120000);
        model_rx = 8'h12;
        total++; if (rx_data !== 8'h12 || rxv_cnt != 1) begin
            bad++; $display("FAIL midrst_next_frame got rx=%h rxv=%0d exp rx=12 rxv=1", rx_data, rxv_cnt);
        end
    endtask

    task automatic test_idle_noise();
        int miso_low;
        miso_low = 0;
        clear_counts();
        cs_n = 1'b1;
        for (int t = 0; t < 16; t++) begin
            sck = ~sck;
            mosi = 1'($urandom);
            repeat ($urandom_range(1, 4)) begin
                tick();
                if (miso !== 1'b1) miso_low++;
            end
        end
        wait_ticks(S + 4);
        total++; if (rxv_cnt != 0 || txl_cnt != 0) begin
            bad++; $display("FAIL idle_noise_pulses got rxv=%0d txl=%0d exp 0 0", rxv_cnt, txl_cnt);
        end
        total++; if (miso_low != 0) begin bad++; $display("FAIL idle_noise_miso got=%0d exp=0 non-1 samples", miso_low); end
        total++; if (rx_data !== model_rx) begin bad++; $display("FAIL idle_noise_rx got=%h exp=%h", rx_data, model_rx); end
    endtask

    task automatic test_random_frames();
        logic [23:0] w;
        logic [7:0]  g;
        int nbits;
        int full;
        for (int f = 0; f < 8; f++) begin
            nbits = $urandom_range(1, 24);
            w = 24'($urandom);
            full = nbits / 8;
            tx_src.delete();
            repeat (3) tx_src.push_back(8'($urandom));
            exp_q.delete();
            for (int i = 0; i < full; i++) exp_q.push_back(w[23-8*i -: 8]);
            if (full > 0) model_rx = exp_q[full-1];
            run_frame(nbits, w);
            total++; if (rxv_cnt != full) begin bad++; $display("FAIL rnd%0d_rxv got=%0d exp=%0d", f, rxv_cnt, full); end
            for (int i = 0; i < full; i++) begin
                g = (i < got_q.size()) ? got_q[i] : 8'hxx;
                total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_rx_byte%0d got=%h exp=%h", f, i, g, exp_q[i]); end
                g = (i < m_in.size()) ? m_in[i] : 8'hxx;
                total++; if (g !== tx_src[i]) begin bad++; $display("FAIL rnd%0d_miso_byte%0d got=%h exp=%h", f, i, g, tx_src[i]); end
            end
            total++; if (rx_data !== model_rx) begin bad++; $display("FAIL rnd%0d_rx_data got=%h exp=%h", f, rx_data, model_rx); end
            total++; if (txl_cnt != 1 + (nbits - 1) / 8) begin
                bad++; $display("FAIL rnd%0d_txl got=%0d exp=%0d", f, txl_cnt, 1 + (nbits - 1) / 8);
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            total++; if (ferr_cnt != ((nbits % 8 != 0) ? 1 : 0)) begin
                bad++; $display("FAIL rnd%0d_frame_err got=%0d exp=%0d", f, ferr_cnt, (nbits % 8 != 0) ? 1 : 0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_partial_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_noise();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
